timer_dev: RTL and testbench

Memory-mapped countdown timer on the data-memory side of the system bridge, downstream of the memory-stage byte-enable unit. Takes the byte enables, word-aligned store data and register select that the memory stage drives. Returns read data that passes back through load extension. Raises an interrupt request toward CP0 when a programmed count expires, in one-shot or auto-reload mode.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/timer_dev.sv | 104 ++++++++++
 tb/tb_timer_dev.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM states, register map
// indices, CTRL field positions and mode encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and (optional) auto-reload modes.
// Define TIMER_AUTORELOAD_EN to implement mode 1 reload; otherwise all modes are one-shot.
module timer_dev
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [3:0]  byte_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        word_wr;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        reload_mode;
    logic        expire;
    logic [3:0]  ctrl_nxt;
    logic        flag_nxt;

    // Partial byte enables are dropped outright; there is no lane merge.
    assign word_wr   = (byte_en == 4'b1111);
    assign ctrl_wr   = word_wr && (addr == REG_CTRL);
    assign preset_wr = word_wr && (addr == REG_PRESET);

`ifdef TIMER_AUTORELOAD_EN
    assign reload_mode = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
`else
    assign reload_mode = 1'b0;
`endif

    assign expire = (state == ST_CNT) && ctrl[CTRL_EN] && (count <= 32'd1);

    // Later assignments take priority: FSM update, then software write, then expiry set.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        ctrl_nxt = ctrl;
        flag_nxt = irq_flag;
        if (state == ST_INT) begin
            if (reload_mode) flag_nxt = 1'b0;
            else             ctrl_nxt[CTRL_EN] = 1'b0;
        end
        if (ctrl_wr)              ctrl_nxt = wdata[3:0];
        if (ctrl_wr || preset_wr) flag_nxt = 1'b0;
        if (expire)               flag_nxt = 1'b1;
    end

    // irq is driven from next-state values so it rises on the same edge as irq_flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading pre-edge values.
        if (reset) begin
            state    <= ST_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            ctrl     <= ctrl_nxt;
            irq_flag <= flag_nxt;
            irq      <= flag_nxt & ctrl_nxt[CTRL_IM];
            if (preset_wr) preset <= wdata;

            case (state)
                ST_IDLE: if (ctrl[CTRL_EN]) state <= ST_LOAD;
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= 32'd0;
                        state <= ST_INT;
                    end
                end
                ST_INT:  state <= reload_mode ? ST_LOAD : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            REG_CTRL:   rdata = {28'd0, ctrl};
            REG_PRESET: rdata = preset;
            REG_COUNT:  rdata = count;
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev; expectations follow the edge-numbered timing
// of the timer (EN written at edge t, LOAD at t+1, COUNT=P at t+2, irq at t+2+P).
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;
    localparam logic [3:0] FULL     = 4'b1111;

    timer_dev dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .byte_en (byte_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write lands on the next rising edge; returns 1 ns after that edge.
    task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        addr    = a;
        byte_en = be;
        wdata   = d;
        @(posedge clk);
        #1;
        byte_en = 4'b0000;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    logic [12:1] irq_trace;
    logic [12:1] irq_exp;

    initial begin
        reset   = 1'b1;
        addr    = 2'd0;
        byte_en = 4'b0000;
        wdata   = 32'd0;
        tick(2);
        reset = 1'b0;

        // Reset state
        chk_reg("rst_ctrl",   A_CTRL,   32'd0);
        chk_reg("rst_preset", A_PRESET, 32'd0);
        chk_reg("rst_count",  A_COUNT,  32'd0);
        chk_reg("rst_rsvd",   A_RSVD,   32'd0);
        chk_irq("rst_irq", 1'b0);

        // Reset mid-count: PRESET=5, reset when COUNT=3
        wr(A_PRESET, FULL, 32'd5);
        wr(A_CTRL, FULL, 32'h1);            // edge t
        tick(2);                            // t+2
        chk_reg("mid_count5", A_COUNT, 32'd5);
        tick(2);                            // t+4
        chk_reg("mid_count3", A_COUNT, 32'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reg("mid_rst_ctrl",   A_CTRL,   32'd0);
        chk_reg("mid_rst_count",  A_COUNT,  32'd0);
        chk_reg("mid_rst_preset", A_PRESET, 32'd0);
        chk_irq("mid_rst_irq", 1'b0);
        tick(3);
        chk_reg("mid_rst_idle_count", A_COUNT, 32'd0);

        // One-shot, PRESET=3, IM=1
        wr(A_PRESET, FULL, 32'd3);
        wr(A_CTRL, FULL, 32'h9);            // edge t
        tick();                             // t+1 (LOAD)
        chk_reg("os_count_load", A_COUNT, 32'd0);
        tick();                             // t+2
        chk_reg("os_count3", A_COUNT, 32'd3);
        chk_irq("os_irq_t2", 1'b0);
        tick();
        chk_reg("os_count2", A_COUNT, 32'd2);
        tick();
        chk_reg("os_count1", A_COUNT, 32'd1);
        chk_irq("os_irq_t4", 1'b0);
        tick();                             // t+5
        chk_reg("os_count0", A_COUNT, 32'd0);
        chk_irq("os_irq_t5", 1'b1);
        tick(2);                            // t+7
        chk_irq("os_irq_hold", 1'b1);
        chk_reg("os_ctrl_en_clr", A_CTRL, 32'h8);
        wr(A_CTRL, FULL, 32'h8);
        chk_irq("os_irq_cleared", 1'b0);
        tick();
        chk_irq("os_irq_stays_low", 1'b0);

        // Write filtering
        wr(A_PRESET, 4'b0011, 32'hDEADBEEF);
        chk_reg("filt_preset_partial", A_PRESET, 32'd3);
        wr(A_PRESET, 4'b0000, 32'h12345678);
        chk_reg("filt_preset_none", A_PRESET, 32'd3);
        wr(A_COUNT, FULL, 32'h55);
        chk_reg("filt_count_ro", A_COUNT, 32'd0);
        wr(A_RSVD, FULL, 32'hFFFFFFFF);
        chk_reg("filt_rsvd", A_RSVD, 32'd0);
        wr(A_CTRL, 4'b0111, 32'h1);
        chk_reg("filt_ctrl_partial", A_CTRL, 32'h8);
        tick(3);
        chk_reg("filt_no_start", A_COUNT, 32'd0);

        // Disable at COUNT=4, then re-enable from IDLE
        wr(A_PRESET, FULL, 32'd10);
        wr(A_CTRL, FULL, 32'h1);            // edge t
        tick(7);                            // t+7, COUNT=5
        chk_reg("dis_count5", A_COUNT, 32'd5);
        wr(A_CTRL, FULL, 32'h0);            // edge t+8, COUNT becomes 4
        chk_reg("dis_count4", A_COUNT, 32'd4);
        tick(3);
        chk_reg("dis_frozen", A_COUNT, 32'd4);
        wr(A_CTRL, FULL, 32'h1);            // edge u
        tick();                             // u+1 LOAD
        chk_reg("reen_load_cycle", A_COUNT, 32'd4);
        tick();                             // u+2
        chk_reg("reen_count10", A_COUNT, 32'd10);
        wr(A_CTRL, FULL, 32'h0);
        tick(2);

        // Masked expiry with PRESET=0 (behaves as 1): flag set, irq stays low
        wr(A_PRESET, FULL, 32'd0);
        wr(A_CTRL, FULL, 32'h1);            // edge t, IM=0
        tick(2);                            // t+2
        chk_irq("mask_irq_t2", 1'b0);
        tick();                             // t+3 expiry
        chk_irq("mask_irq_t3", 1'b0);
        check("mask_flag_set", {31'd0, dut.irq_flag}, 32'd1);
        tick();                             // t+4 INT -> IDLE
        chk_reg("mask_ctrl_en_clr", A_CTRL, 32'h0);
        wr(A_CTRL, FULL, 32'h8);
        chk_irq("mask_unmask_irq", 1'b0);
        check("mask_flag_clr", {31'd0, dut.irq_flag}, 32'd0);
        tick();
        chk_irq("mask_unmask_irq2", 1'b0);

        // PRESET=0 with IM=1: irq at t+3
        wr(A_CTRL, FULL, 32'h9);            // edge t
        tick(2);
        chk_irq("p0_irq_t2", 1'b0);
        tick();
        chk_irq("p0_irq_t3", 1'b1);
        wr(A_CTRL, FULL, 32'h0);
        chk_irq("p0_irq_clr", 1'b0);
        tick(2);

        // PRESET written mid-count; PRESET write on the expiry edge (set wins)
        wr(A_PRESET, FULL, 32'd3);
        wr(A_CTRL, FULL, 32'h9);            // edge t
        tick(2);                            // t+2
        wr(A_PRESET, FULL, 32'd6);          // edge t+3
        chk_reg("pw_count2", A_COUNT, 32'd2);
        tick();                             // t+4
        chk_reg("pw_count1", A_COUNT, 32'd1);
        wr(A_PRESET, FULL, 32'd6);          // edge t+5, expiry
        chk_irq("pw_set_wins", 1'b1);
        chk_reg("pw_count0", A_COUNT, 32'd0);
        tick(2);
        chk_reg("pw_ctrl", A_CTRL, 32'h8);
        wr(A_CTRL, FULL, 32'h9);            // edge u
        chk_irq("pw_irq_clr", 1'b0);
        tick(2);                            // u+2
        chk_reg("pw_new_preset", A_COUNT, 32'd6);
        wr(A_CTRL, FULL, 32'h0);
        tick(3);

        // Auto-reload, PRESET=2, CTRL=0xB
        wr(A_PRESET, FULL, 32'd2);
        wr(A_CTRL, FULL, 32'hB);            // edge t
        for (int k = 1; k <= 12; k++) begin
            tick();
            irq_trace[k] = irq;
        end
`ifdef TIMER_AUTORELOAD_EN
        irq_exp = 12'b1000_1000_1000;
        check("ar_irq_trace", {20'd0, irq_trace}, {20'd0, irq_exp});
        chk_reg("ar_ctrl", A_CTRL, 32'hB);
`else
        irq_exp = 12'b1111_1111_1000;
        check("ar_irq_trace", {20'd0, irq_trace}, {20'd0, irq_exp});
        chk_reg("ar_ctrl", A_CTRL, 32'hA);
`endif
        wr(A_CTRL, FULL, 32'h0);
        chk_irq("ar_irq_off", 1'b0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
